// File: rtl/sd_host_pkg.sv
// Shared types and default sizing for the SD host register-access path.
package sd_host_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // One-hot two-way grant to requester index (bit 1 set means requester 1).
  function automatic logic grant_index(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant selection; 'last' is the index of the requester served most recently.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares one register-set port between the host bus and the SD command engine,
// with round-robin grant, registered handshake outputs and an m_ack timeout.
module reg_access_arbiter
  import sd_host_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req,
  input  logic [1:0]              wnr,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic                    m_req,
  output logic                    m_wnr,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic                    m_ack,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [1:0]       grant;
  logic             sel;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             start;
  logic             hit;
  logic             expire;

  rr_arbiter_2 u_rr (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // m_ack is only looked at in BUSY, so stray acks in IDLE/DONE have no effect.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    hit        = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          start      = 1'b1;
          state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (m_ack) begin
          hit        = 1'b1;
          state_next = DONE;
        end else if (cnt == TO_LAST) begin
          expire     = 1'b1;
          state_next = DONE;
        end else begin
          state_next = BUSY;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel     <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      ack     <= 2'b00;
      rdata   <= '0;
      err     <= 1'b0;
      m_req   <= 1'b0;
      m_wnr   <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      ack <= 2'b00;
      if (start) begin
        sel     <= grant_index(grant);
        cnt     <= '0;
        m_req   <= 1'b1;
        m_wnr   <= grant[1] ? wnr[1] : wnr[0];
        m_addr  <= grant[1] ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
        m_wdata <= grant[1] ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
      end else if (hit || expire) begin
        // hit takes precedence, so an ack landing on the last BUSY cycle reports no error
        m_req <= 1'b0;
        ack   <= sel ? 2'b10 : 2'b01;
        rdata <= (hit && !m_wnr) ? m_rdata : '0;
        err   <= expire;
        last  <= sel;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a completion scoreboard.
module tb_reg_access_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  wnr = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        err;
  logic        m_req;
  logic        m_wnr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [15:0] m_rdata = 16'h0;

  typedef struct {
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  reg_access_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wnr     (wnr),
    .addr    (addr),
    .wdata   (wdata),
    .ack     (ack),
    .rdata   (rdata),
    .err     (err),
    .m_req   (m_req),
    .m_wnr   (m_wnr),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic [15:0] d, input logic e);
    exp_t x;
    x.ack = a;
    x.rdata = d;
    x.err = e;
    sbq.push_back(x);
  endtask

  task automatic pop_check(input string tag);
    exp_t x;
    n_checks++;
    assert (sbq.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb got=empty exp=entry", tag);
    end
    if (sbq.size() != 0) begin
      x = sbq.pop_front();
      check({tag, "_ack"}, {30'd0, ack}, {30'd0, x.ack});
      check({tag, "_rdata"}, {16'd0, rdata}, {16'd0, x.rdata});
      check({tag, "_err"}, {31'd0, err}, {31'd0, x.err});
    end
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int i;
    tick();
    i = 1;
    while (ack === 2'b00 && i < budget) begin
      tick();
      i++;
    end
    n_checks++;
    assert (ack !== 2'b00) else begin
      n_fail++;
      $error("FAIL %s_wait got=no_ack exp=ack_within_%0d", tag, budget);
    end
    pop_check(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;

    // reset state
    do_reset();
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_m_req", {31'd0, m_req}, 32'd0);
    check("rst_m_wnr", {31'd0, m_wnr}, 32'd0);
    check("rst_m_addr", {16'd0, m_addr}, 32'd0);
    check("rst_m_wdata", {16'd0, m_wdata}, 32'd0);

    // host read, best-case latency
    req = 2'b01; wnr = 2'b00; addr = {16'h0000, 16'h0004};
    push(2'b01, 16'hBEEF, 1'b0);
    tick();
    check("rd_m_req", {31'd0, m_req}, 32'd1);
    check("rd_m_addr", {16'd0, m_addr}, 32'h0004);
    check("rd_m_wnr", {31'd0, m_wnr}, 32'd0);
    tick();
    check("rd_m_req_c2", {31'd0, m_req}, 32'd1);
    m_ack = 1'b1; m_rdata = 16'hBEEF;
    wait_ack("rd", 1);
    m_ack = 1'b0; m_rdata = 16'h0; req = 2'b00;
    check("rd_m_req_done", {31'd0, m_req}, 32'd0);
    tick();
    check("rd_ack_pulse", {30'd0, ack}, 32'd0);

    // engine write; write returns zero data
    req = 2'b10; wnr = 2'b10; addr = {16'h0010, 16'h0000}; wdata = {16'h1234, 16'h0000};
    push(2'b10, 16'h0000, 1'b0);
    tick();
    check("wr_m_req", {31'd0, m_req}, 32'd1);
    check("wr_m_wnr", {31'd0, m_wnr}, 32'd1);
    check("wr_m_addr", {16'd0, m_addr}, 32'h0010);
    check("wr_m_wdata", {16'd0, m_wdata}, 32'h1234);
    m_ack = 1'b1; m_rdata = 16'hDEAD;
    wait_ack("wr", 1);
    m_ack = 1'b0; m_rdata = 16'h0; req = 2'b00; wnr = 2'b00;
    tick();

    // simultaneous requests held across three accesses: grants 0,1,0
    do_reset();
    req = 2'b11; wnr = 2'b00; addr = {16'h0200, 16'h0100};
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rr%0d_m_req", k), {31'd0, m_req}, 32'd1);
      check($sformatf("rr%0d_m_addr", k), {16'd0, m_addr}, (k == 1) ? 32'h0200 : 32'h0100);
      m_ack = 1'b1; m_rdata = 16'hC000 + 16'(k);
      push((k == 1) ? 2'b10 : 2'b01, 16'hC000 + 16'(k), 1'b0);
      wait_ack($sformatf("rr%0d", k), 1);
      m_ack = 1'b0; m_rdata = 16'h0;
      if (k == 2) req = 2'b00;
      check($sformatf("rr%0d_gap1", k), {31'd0, m_req}, 32'd0);
      tick();
      check($sformatf("rr%0d_gap2", k), {31'd0, m_req}, 32'd0);
    end

    // timeout: m_req high for exactly 16 cycles, then err with zero data
    req = 2'b01; addr = {16'h0000, 16'h0040}; m_rdata = 16'hFFFF;
    push(2'b01, 16'h0000, 1'b1);
    tick();
    n = 0;
    while (m_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("to_len", n, 32'd16);
    pop_check("to");
    req = 2'b00; m_rdata = 16'h0;
    tick();

    // normal access after timeout
    req = 2'b01; addr = {16'h0000, 16'h0008};
    push(2'b01, 16'h5A5A, 1'b0);
    tick();
    m_ack = 1'b1; m_rdata = 16'h5A5A;
    wait_ack("post_to", 1);
    m_ack = 1'b0; req = 2'b00;
    tick();

    // m_ack on the final counted cycle wins over timeout
    req = 2'b01; addr = {16'h0000, 16'h0044};
    push(2'b01, 16'h7777, 1'b0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("co_m_req", {31'd0, m_req}, 32'd1);
    m_ack = 1'b1; m_rdata = 16'h7777;
    wait_ack("coincide", 1);
    m_ack = 1'b0; m_rdata = 16'h0; req = 2'b00;
    tick();

    // reset mid-BUSY abandons the access; later m_ack ignored
    req = 2'b10; addr = {16'h0300, 16'h0000};
    tick();
    check("mr_m_req", {31'd0, m_req}, 32'd1);
    req = 2'b00; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_m_req_off", {31'd0, m_req}, 32'd0);
    check("mr_ack", {30'd0, ack}, 32'd0);
    m_ack = 1'b1; m_rdata = 16'h4444;
    tick();
    tick();
    check("mr_stray_ack", {30'd0, ack}, 32'd0);
    check("mr_stray_m_req", {31'd0, m_req}, 32'd0);
    m_ack = 1'b0; m_rdata = 16'h0;

    // pointer back to favouring requester 0
    req = 2'b11; addr = {16'h0300, 16'h0020};
    push(2'b01, 16'h1111, 1'b0);
    tick();
    check("mr_grant_addr", {16'd0, m_addr}, 32'h0020);
    m_ack = 1'b1; m_rdata = 16'h1111;
    wait_ack("mr_host", 1);
    m_ack = 1'b0; m_rdata = 16'h0; req = 2'b00;
    tick();
    check("sb_drained", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 16, register data width.
- ADDR_WIDTH, default 16, register address width.
- TIMEOUT, default 16, maximum cycles to wait for m_ack.
REQ-002 Ports SHALL be (index 0 = host bus requester, index 1 = SD command engine requester; per-requester buses are packed, slot i at [W*i +: W]):
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester access request, level.
- wnr  in  2  per-requester direction: 0 read, 1 write.
- addr  in  2*ADDR_WIDTH  per-requester register address.
- wdata  in  2*DATA_WIDTH  per-requester write data.
- ack  out  2  per-requester completion pulse, one cycle.
- rdata  out  DATA_WIDTH  read data, valid while any ack bit is 1.
- err  out  1  timeout flag, valid while any ack bit is 1.
- m_req  out  1  request to the register set.
- m_wnr  out  1  direction to the register set.
- m_addr  out  ADDR_WIDTH  address to the register set.
- m_wdata  out  DATA_WIDTH  write data to the register set.
- m_ack  in  1  register set completion.
- m_rdata  in  DATA_WIDTH  register set read data.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-004 In IDLE with any req bit set, the block SHALL grant one requester and latch that requester's wnr, addr and wdata into the m_* registers, then go to BUSY.
REQ-005 Arbitration SHALL be round-robin: when both requesters assert req, the grant goes to the requester not served last; a single requester wins regardless of the pointer.
REQ-006 The last-served pointer SHALL update when the block enters DONE.
REQ-007 In BUSY, m_req SHALL be 1, and m_wnr, m_addr and m_wdata SHALL stay stable until exit.
REQ-008 In BUSY with m_ack=1, the block SHALL capture m_rdata (0 for writes), set err=0 and go to DONE.
REQ-009 A BUSY cycle counter SHALL start at 0 on entry to BUSY.
REQ-010 If the counter reaches TIMEOUT-1 with m_ack=0, the block SHALL set err=1, set rdata=0 and go to DONE.
REQ-011 If m_ack and the timeout coincide, m_ack SHALL win and err SHALL be 0.
REQ-012 In DONE, ack[grant] SHALL be 1 for exactly one cycle with rdata and err valid, then the block SHALL return to IDLE. The other ack bit SHALL stay 0.
REQ-013 m_req SHALL be 0 in IDLE and DONE, so successive register-set accesses are separated by at least two idle cycles.
REQ-014 Best-case latency SHALL be: req sampled at edge 0 -> m_req at cycle 1 -> m_ack at cycle 2 -> ack at cycle 3.
REQ-015 A requester SHALL hold req, wnr, addr and wdata until its ack, and SHALL deassert req on the edge that ends its ack cycle.
REQ-016 req still high in the IDLE cycle after that edge SHALL count as a new request.
REQ-017 A requester dropping req while its grant is in BUSY SHALL NOT abort the access; the ack SHALL still be pulsed.
REQ-018 m_ack received in IDLE or DONE SHALL be ignored.

Reset
REQ-019 On reset=1 at a clock edge, the block SHALL take these values:
- state IDLE, round-robin pointer favouring requester 0.
- ack=0, err=0, rdata=0.
- m_req=0, m_wnr=0, m_addr=0, m_wdata=0.
- timeout counter 0.
REQ-020 Reset during BUSY or DONE SHALL abandon the in-flight access with no ack issued.

Structure
REQ-021 The state enum (arb_state_t) and the default DATA_WIDTH, ADDR_WIDTH and TIMEOUT values SHALL live in the shared package sd_host_pkg.
REQ-022 The round-robin grant selection SHALL be a combinational sub-module rr_arbiter_2 (inputs req[1:0] and the last-served pointer; output one-hot grant[1:0]).
REQ-023 The timeout counter width SHALL be $clog2(TIMEOUT)+1.

Verification
REQ-024 Host read: req=2'b01, wnr=0, addr0=0x0004, m_ack one cycle after m_req, m_rdata=0xBEEF -> m_addr=0x0004, then ack=2'b01, rdata=0xBEEF, err=0, at cycle 3.
REQ-025 Simultaneous: req=2'b11 held across three back-to-back accesses after reset -> grants in order 0, 1, 0; m_req low at least two cycles between accesses.
REQ-026 Engine write: req=2'b10, wnr=1, addr1=0x0010, wdata1=0x1234 -> m_wnr=1, m_addr=0x0010, m_wdata=0x1234, then ack=2'b10, rdata=0.
REQ-027 Timeout: m_ack never asserted -> m_req high for exactly 16 cycles, then ack with err=1, rdata=0; next request proceeds normally.
REQ-028 Reset mid-BUSY: reset pulsed with m_req=1 -> next cycle m_req=0, ack=0; a later m_ack is ignored; a subsequent host request grants requester 0.
